// File: rtl/exp5_fluxo_dados_pkg.sv
// Shared constants for the sequence-memory game datapath: widths, timer default
// and the fixed one-hot play sequence held in ROM.
package exp5_fluxo_dados_pkg;

  localparam int unsigned CNT_W                  = 4;
  localparam int unsigned REG_W                  = 4;
  localparam int unsigned BTN_W                  = 4;
  localparam int unsigned ROM_DEPTH              = 16;
  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 5000;

  localparam logic [REG_W-1:0] SEQ_ROM [ROM_DEPTH] = '{
    4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
    4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4
  };

  function automatic logic [REG_W-1:0] rom_read(input logic [CNT_W-1:0] addr);
    return SEQ_ROM[addr];
  endfunction

endpackage

// File: rtl/exp5_fluxo_dados_contador_m.sv
// Modulo-M synchronous counter with clear priority over count. With HOLD_AT_MAX
// set, the count parks at M-1 instead of wrapping.
module contador_m #(
  parameter int unsigned M           = 16,
  parameter int unsigned W           = (M > 1) ? $clog2(M) : 1,
  parameter bit          HOLD_AT_MAX = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] MAX = W'(M - 1);

  // Count register: clear wins, then increment / wrap / hold at the terminal value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else if (zera) begin
      q <= '0;
    end else if (conta) begin
      if (q == MAX) begin
        q <= HOLD_AT_MAX ? q : '0;
      end else begin
        q <= q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/exp5_fluxo_dados.sv
// Datapath of the sequence-memory game: address counter E, round limit L, play
// register R, sequence ROM, button edge detector and inactivity timer, all
// reporting status flags back to the control unit.
module exp5_fluxo_dados
  import exp5_fluxo_dados_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             zeraE,
  input  logic             contaE,
  input  logic             zeraL,
  input  logic             contaL,
  input  logic             zeraR,
  input  logic             registraR,
  input  logic             contaT,
  input  logic [BTN_W-1:0] botoes,
  output logic             fimE,
  output logic             fimL,
  output logic             igualE,
  output logic             igualL,
  output logic             jogada,
  output logic             timeout,
  output logic [CNT_W-1:0] db_contagem,
  output logic [CNT_W-1:0] db_limite,
  output logic [REG_W-1:0] db_memoria,
  output logic [REG_W-1:0] db_jogada
);

  localparam int unsigned   TMR_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] e;
  logic [CNT_W-1:0] l;
  logic [REG_W-1:0] r;
  logic [REG_W-1:0] mem;
  logic [TMR_W-1:0] tmr;
  logic             any_btn;
  logic             btn_d;
  logic             tmr_clr;

  contador_m #(.M(ROM_DEPTH), .W(CNT_W), .HOLD_AT_MAX(1'b0)) u_cnt_e (
    .clock (clock),
    .reset (reset),
    .zera  (zeraE),
    .conta (contaE),
    .q     (e)
  );

  contador_m #(.M(ROM_DEPTH), .W(CNT_W), .HOLD_AT_MAX(1'b0)) u_cnt_l (
    .clock (clock),
    .reset (reset),
    .zera  (zeraL),
    .conta (contaL),
    .q     (l)
  );

  // The timer runs only while enabled and is cleared on any idle cycle.
  assign tmr_clr = ~contaT;

  contador_m #(.M(TIMEOUT_CYCLES), .W(TMR_W), .HOLD_AT_MAX(1'b1)) u_cnt_t (
    .clock (clock),
    .reset (reset),
    .zera  (tmr_clr),
    .conta (contaT),
    .q     (tmr)
  );

  // Play register: clear beats load.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r <= '0;
    end else if (zeraR) begin
      r <= '0;
    end else if (registraR) begin
      r <= botoes;
    end
  end

  assign any_btn = |botoes;

  // Remember whether any button was down last cycle for rising-edge detection.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      btn_d <= 1'b0;
    end else begin
      btn_d <= any_btn;
    end
  end

  // Status flags and debug taps.
  always_comb begin
    mem         = rom_read(e);
    fimE        = (e == 4'hF);
    fimL        = (l == 4'hF);
    igualE      = (r == mem);
    igualL      = (e == l);
    jogada      = any_btn & ~btn_d;
    timeout     = contaT & (tmr == TMR_MAX);
    db_contagem = e;
    db_limite   = l;
    db_memoria  = mem;
    db_jogada   = r;
  end

endmodule

// File: tb/tb_exp5_fluxo_dados.sv
module tb_exp5_fluxo_dados;

  localparam int TC = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       zeraE, contaE, zeraL, contaL, zeraR, registraR, contaT;
  logic [3:0] botoes;
  logic       fimE, fimL, igualE, igualL, jogada, timeout;
  logic [3:0] db_contagem, db_limite, db_memoria, db_jogada;

  exp5_fluxo_dados #(.TIMEOUT_CYCLES(TC)) dut (
    .clock       (clock),
    .reset       (reset),
    .zeraE       (zeraE),
    .contaE      (contaE),
    .zeraL       (zeraL),
    .contaL      (contaL),
    .zeraR       (zeraR),
    .registraR   (registraR),
    .contaT      (contaT),
    .botoes      (botoes),
    .fimE        (fimE),
    .fimL        (fimL),
    .igualE      (igualE),
    .igualL      (igualL),
    .jogada      (jogada),
    .timeout     (timeout),
    .db_contagem (db_contagem),
    .db_limite   (db_limite),
    .db_memoria  (db_memoria),
    .db_jogada   (db_jogada)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state: plain integers, streak is an unbounded run length.
  int m_e, m_l, m_r, m_streak;
  bit m_btn_prev;
  logic [3:0] rom_ref [16];

  typedef struct {
    logic       ze, ce, zl, cl, zr, rr, ct;
    logic [3:0] btn;
    logic       x_jog;
    logic [3:0] x_e, x_l, x_r;
    logic       x_ige, x_igl;
  } vec_t;

  vec_t vecs [8];

  function automatic vec_t mk(input logic ze, ce, zl, cl, zr, rr, ct, input logic [3:0] btn,
                              input logic xj, input logic [3:0] xe, xl, xr,
                              input logic xige, xigl);
    vec_t v;
    v.ze = ze; v.ce = ce; v.zl = zl; v.cl = cl; v.zr = zr; v.rr = rr; v.ct = ct;
    v.btn = btn; v.x_jog = xj; v.x_e = xe; v.x_l = xl; v.x_r = xr;
    v.x_ige = xige; v.x_igl = xigl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    zeraE = 0; contaE = 0; zeraL = 0; contaL = 0;
    zeraR = 0; registraR = 0; contaT = 0; botoes = 4'h0;
  endtask

  task automatic model_reset();
    m_e = 0; m_l = 0; m_r = 0; m_streak = 0; m_btn_prev = 0;
  endtask

  // One rising edge; model advances from the inputs present at that edge.
  task automatic tick();
    @(posedge clock);
    if (zeraE) m_e = 0; else if (contaE) m_e = (m_e + 1) % 16;
    if (zeraL) m_l = 0; else if (contaL) m_l = (m_l + 1) % 16;
    if (zeraR) m_r = 0; else if (registraR) m_r = int'(botoes);
    m_btn_prev = (botoes != 0);
    m_streak   = contaT ? m_streak + 1 : 0;
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".fimE"},    fimE,        32'(m_e == 15));
    chk({tag, ".fimL"},    fimL,        32'(m_l == 15));
    chk({tag, ".igualE"},  igualE,      32'(m_r == int'(rom_ref[m_e])));
    chk({tag, ".igualL"},  igualL,      32'(m_e == m_l));
    chk({tag, ".jogada"},  jogada,      32'((botoes != 0) && !m_btn_prev));
    chk({tag, ".timeout"}, timeout,     32'(contaT && (m_streak >= TC - 1)));
    chk({tag, ".E"},       db_contagem, 32'(m_e));
    chk({tag, ".L"},       db_limite,   32'(m_l));
    chk({tag, ".mem"},     db_memoria,  32'(rom_ref[m_e]));
    chk({tag, ".R"},       db_jogada,   32'(m_r));
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #7;
    reset = 1'b0;
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  initial begin
    int pulses;
    rom_ref = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h4, 4'h2, 4'h1, 4'h1,
                4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1, 4'h4};

    //            ze ce zl cl zr rr ct btn   jog E     L     R     igE igL
    vecs[0] = mk(0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 4'h1, 4'h0, 4'h0, 0, 0);
    vecs[1] = mk(0, 1, 0, 1, 0, 0, 0, 4'h0, 0, 4'h2, 4'h1, 4'h0, 0, 0);
    vecs[2] = mk(0, 0, 0, 1, 0, 0, 0, 4'h0, 0, 4'h2, 4'h2, 4'h0, 0, 1);
    vecs[3] = mk(1, 1, 0, 0, 0, 0, 0, 4'h0, 0, 4'h0, 4'h2, 4'h0, 0, 0);
    vecs[4] = mk(0, 0, 0, 0, 0, 1, 0, 4'h1, 1, 4'h0, 4'h2, 4'h1, 1, 0);
    vecs[5] = mk(0, 0, 0, 0, 1, 1, 0, 4'h1, 0, 4'h0, 4'h2, 4'h0, 0, 0);
    vecs[6] = mk(0, 0, 0, 0, 0, 1, 0, 4'h2, 0, 4'h0, 4'h2, 4'h2, 0, 0);
    vecs[7] = mk(0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 4'h1, 4'h2, 4'h2, 1, 0);

    // Reset values
    do_reset();
    chk("rst.E", db_contagem, 0);
    chk("rst.igualL", igualL, 1);
    chk("rst.igualE", igualE, 0);
    chk("rst.mem", db_memoria, 4'h1);
    chk("rst.timeout", timeout, 0);
    check_model("rst");

    // Table-driven vectors
    for (int i = 0; i < 8; i++) begin
      zeraE = vecs[i].ze; contaE = vecs[i].ce; zeraL = vecs[i].zl; contaL = vecs[i].cl;
      zeraR = vecs[i].zr; registraR = vecs[i].rr; contaT = vecs[i].ct; botoes = vecs[i].btn;
      #1;
      chk($sformatf("vec%0d.jogada", i), jogada, vecs[i].x_jog);
      tick();
      chk($sformatf("vec%0d.E", i), db_contagem, vecs[i].x_e);
      chk($sformatf("vec%0d.L", i), db_limite, vecs[i].x_l);
      chk($sformatf("vec%0d.R", i), db_jogada, vecs[i].x_r);
      chk($sformatf("vec%0d.igualE", i), igualE, vecs[i].x_ige);
      chk($sformatf("vec%0d.igualL", i), igualL, vecs[i].x_igl);
    end

    // Counter wrap: fimE only at 15, then back to 0
    idle_inputs(); zeraE = 1; tick();
    zeraE = 0; contaE = 1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("wrap%0d.fimE", k), fimE, 32'(k == 15));
      chk($sformatf("wrap%0d.E", k), db_contagem, 32'(k % 16));
    end

    // Held button: exactly one pulse over 5 cycles
    idle_inputs(); tick();
    botoes = 4'h1; pulses = 0;
    for (int k = 0; k < 5; k++) begin
      #1;
      if (jogada) pulses++;
      tick();
    end
    chk("held.pulses", pulses, 1);

    // Correct play at E=0, wrong at E=3
    idle_inputs(); zeraE = 1; zeraL = 1; zeraR = 1; tick();
    idle_inputs(); botoes = 4'h1; registraR = 1; tick();
    chk("play0.R", db_jogada, 4'h1);
    chk("play0.igualE", igualE, 1);
    idle_inputs(); contaE = 1; tick(); tick(); tick();
    idle_inputs(); botoes = 4'h1; registraR = 1; tick();
    chk("play3.E", db_contagem, 3);
    chk("play3.igualE", igualE, 0);

    // Round limit
    idle_inputs(); zeraE = 1; zeraL = 1; tick();
    idle_inputs(); contaE = 1; contaL = 1; tick(); tick();
    chk("lim.igualL_eq", igualL, 1);
    idle_inputs(); zeraE = 1; tick();
    idle_inputs(); contaE = 1; tick();
    chk("lim.igualL_ne", igualL, 0);
    idle_inputs();

    // Timeout rises on the TC-th enabled cycle and stays high
    tick();
    contaT = 1;
    for (int i = 1; i <= TC + 2; i++) begin
      #0;
      chk($sformatf("to%0d.timeout", i), timeout, 32'(i >= TC));
      tick();
    end
    contaT = 0;
    #1;
    chk("to.drop", timeout, 0);
    tick();
    contaT = 1;
    for (int i = 1; i <= TC; i++) begin
      chk($sformatf("tore%0d.timeout", i), timeout, 32'(i == TC));
      tick();
    end

    // Button press in the same cycle timeout asserts
    contaT = 0; tick();
    contaT = 1;
    for (int i = 1; i < TC; i++) tick();
    botoes = 4'h4;
    #1;
    chk("sim.jogada", jogada, 1);
    chk("sim.timeout", timeout, 1);
    check_model("sim");
    tick();

    // Asynchronous reset mid-operation
    idle_inputs(); zeraE = 1; tick();
    idle_inputs(); contaE = 1; contaL = 1; registraR = 1; botoes = 4'h8;
    for (int i = 0; i < 5; i++) tick();
    idle_inputs(); contaT = 1;
    for (int i = 0; i < TC; i++) tick();
    chk("pre_rst.E", db_contagem, 5);
    chk("pre_rst.timeout", timeout, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("arst.E", db_contagem, 0);
    chk("arst.L", db_limite, 0);
    chk("arst.R", db_jogada, 0);
    chk("arst.igualL", igualL, 1);
    chk("arst.mem", db_memoria, 4'h1);
    chk("arst.timeout", timeout, 0);
    do_reset();
    check_model("post_rst");

    // Randomized stimulus against the model
    for (int i = 0; i < 400; i++) begin
      int unsigned sel;
      zeraE     = ($urandom_range(7) == 0);
      contaE    = $urandom_range(1);
      zeraL     = ($urandom_range(7) == 0);
      contaL    = ($urandom_range(3) == 0);
      zeraR     = ($urandom_range(7) == 0);
      registraR = ($urandom_range(2) == 0);
      contaT    = ($urandom_range(15) != 0);
      sel = $urandom_range(7);
      case (sel)
        0, 1, 2: botoes = 4'h0;
        3:       botoes = 4'h1;
        4:       botoes = 4'h2;
        5:       botoes = 4'h4;
        6:       botoes = 4'h8;
        default: botoes = 4'($urandom);
      endcase
      #0;
      check_model($sformatf("rnd%0d", i));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
